bpd_harness_sequencer: RTL and testbench
========================================

# bpd_harness_sequencer

Single-port access controller for the DPI branch-predictor harness. Accepts prediction requests from fetch, buffers resolved-branch updates from commit in a FIFO, and issues at most one harness operation per cycle so that predict and update ordering is deterministic. Returns tagged prediction responses one cycle after issue. Sits between the fetch/commit front-end and the predictor harness instance.

## Interface
- UPD_DEPTH, 8: update FIFO entries, power of two, ≥2
- TAG_W, 4: prediction request tag width
- STARVE_LIMIT, 16: deferral cycles before a forced update drain (used only with `BPD_SEQ_STARVE_GUARD_EN`)

- clock  in  1  clock
- reset  in  1  synchronous, active-low
- pred_req_valid  in  1  fetch prediction request
- pred_req_ready  out  1  request accepted this cycle
- pred_req_pc  in  64  branch PC
- pred_req_tag  in  TAG_W  request tag, echoed in the response
- pred_flush  in  1  squash the outstanding response and block issue this cycle
- pred_resp_valid  out  1  prediction result valid
- pred_resp_tag  out  TAG_W  tag of the answered request
- pred_resp_taken  out  1  predicted direction
- upd_valid  in  1  commit update push
- upd_ready  out  1  FIFO can accept
- upd_pc  in  64  resolved branch PC
- upd_taken  in  1  resolved direction
- upd_count  out  log2(UPD_DEPTH)+1  FIFO occupancy
- bp_req_valid  out  1  to harness req_valid
- bp_req_pc  out  64  to harness req_pc
- bp_req_taken  in  1  from harness req_taken; valid the cycle after bp_req_valid
- bp_update_valid  out  1  to harness update_valid
- bp_update_pc  out  64  to harness update_pc
- bp_update_taken  out  1  to harness update_taken

## Operation
- Arbitration each cycle, in priority order:
  1. Force update when the FIFO is full, or when the starve guard fires (macro builds only).
  2. Otherwise issue a prediction if `pred_req_valid` and not `pred_flush`.
  3. Otherwise issue an update if the FIFO is non-empty.
  4. Otherwise idle.
- Never assert `bp_req_valid` and `bp_update_valid` in the same cycle.
- `pred_req_ready` = !force_update && !pred_flush && reset. It is combinational from FIFO state and `pred_flush`, never from `pred_req_valid`.
- `bp_req_valid` = `pred_req_valid` && `pred_req_ready`. `bp_req_pc` = `pred_req_pc` (combinational).
- On issue, register the tag and set a pending flag.
- The next cycle, `pred_resp_valid` = pending && !`pred_flush`. `pred_resp_taken` = `bp_req_taken`. `pred_resp_tag` = registered tag.
- The pending flag clears after one cycle; a flushed response is dropped, not delayed.
- The update FIFO is a circular buffer with wrap-around read/write pointers.
  - `upd_ready` = count < UPD_DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - A push while full is ignored (ready is 0).
- `bp_update_*` drives the FIFO head registered value when an update is issued. Pop happens on issue.
- No bypass: an entry pushed in cycle k is issuable at k+1 at the earliest.
- The harness is assumed to have no backpressure; every issued operation completes.

## Timing
- Reset (reset==0, synchronous) has priority over all activity. While in reset:
  - Empty the FIFO, clear pointers, pending flag and starve counter.
  - All outputs are 0, including `pred_req_ready`, `upd_ready` and `upd_count`.
- Reset mid-operation discards buffered updates and any pending response; no response is emitted for a request issued the cycle before reset.
- Prediction latency: request at edge k produces a response at k+1. Sustained throughput is 1 prediction per cycle when the FIFO is not forcing.
- Update latency: enqueue at k → harness issue at ≥k+1. Full FIFO guarantees drain rate ≥1 per cycle of full.
- `pred_flush` and a full FIFO together: the update issues, no prediction issues, and the response is suppressed.

## Configuration
- `BPD_SEQ_STARVE_GUARD_EN` defined:
  - The starve counter increments each cycle the FIFO is non-empty and no update issues, saturating at STARVE_LIMIT.
  - It resets to 0 on any update issue or on empty.
  - When the count equals STARVE_LIMIT, force an update that cycle.
- Undefined: no counter logic. Updates drain only on idle prediction cycles or when the FIFO is full.

## Test plan
- Reset then `pred_req_valid`=1, pc=0x1000, tag=3 at cycle 0 → `bp_req_valid`=1 at cycle 0; `pred_resp_valid`=1, tag=3, taken=`bp_req_taken` at cycle 1.
- Push 8 updates with no predictions → issued one per cycle starting the cycle after the first push, in FIFO order; `upd_count` returns to 0.
- Continuous predictions while pushing 8 updates → `upd_ready`=0 at count 8; `pred_req_ready`=0 that cycle; the head update issues; the count drops to 7.
- With the macro, STARVE_LIMIT=4, one update queued, continuous predictions → the update issues on the 5th cycle after enqueue and `pred_req_ready`=0 in that cycle. Without the macro, the update never issues until predictions stop.
- Issue a prediction at cycle k, `pred_flush`=1 at k+1 → `pred_resp_valid`=0 at k+1 and no new `bp_req_valid` at k+1.
- Assert reset with 3 updates queued and a response pending → next cycle: `upd_count`=0, `pred_resp_valid`=0, no `bp_update_valid` after release until new pushes.

Source files
------------

// File: rtl/bpd_harness_sequencer.sv
`default_nettype none
// ============================================================================
// bpd_harness_sequencer: one-op-per-cycle predict/update arbiter for the BPD harness (starve guard: BPD_SEQ_STARVE_GUARD_EN)
// Revision: 1.0
// ============================================================================
module bpd_harness_sequencer #(
  parameter int UPD_DEPTH    = 8,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           pred_req_valid_i,
  output logic                           pred_req_ready_o,
  input  logic [63:0]                    pred_req_pc_i,
  input  logic [TAG_W-1:0]               pred_req_tag_i,
  input  logic                           pred_flush_i,
  output logic                           pred_resp_valid_o,
  output logic [TAG_W-1:0]               pred_resp_tag_o,
  output logic                           pred_resp_taken_o,
  input  logic                           upd_valid_i,
  output logic                           upd_ready_o,
  input  logic [63:0]                    upd_pc_i,
  input  logic                           upd_taken_i,
  output logic [$clog2(UPD_DEPTH):0]     upd_count_o,
  output logic                           bp_req_valid_o,
  output logic [63:0]                    bp_req_pc_o,
  input  logic                           bp_req_taken_i,
  output logic                           bp_update_valid_o,
  output logic [63:0]                    bp_update_pc_o,
  output logic                           bp_update_taken_o
);

  localparam int c_PTR_W = $clog2(UPD_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(UPD_DEPTH);

  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q,  count_d;
  logic               pend_q,   pend_d;
  logic [TAG_W-1:0]   tag_q,    tag_d;
  logic [63:0]        mem_pc_q [UPD_DEPTH];
  logic               mem_tk_q [UPD_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_starve_fire;
  logic w_force_upd;
  logic w_issue_pred;
  logic w_issue_upd;
  logic w_push;

  assign w_full  = (count_q == c_DEPTH);
  assign w_empty = (count_q == '0);

`ifdef BPD_SEQ_STARVE_GUARD_EN
  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE = c_STARVE_W'(STARVE_LIMIT);

  logic [c_STARVE_W-1:0] starve_q, starve_d;

  // Counts cycles a non-empty FIFO is passed over; any drain or emptiness restarts it.
  always_comb begin
    starve_d = starve_q;
    if (w_empty || w_issue_upd) begin
      starve_d = '0;
    end else if (starve_q != c_STARVE) begin
      starve_d = starve_q + c_STARVE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign w_starve_fire = (starve_q == c_STARVE);
`else
  logic w_unused_starve_limit;
  assign w_unused_starve_limit = |STARVE_LIMIT;
  assign w_starve_fire         = 1'b0;
`endif

  assign w_force_upd  = w_full | w_starve_fire;
  assign pred_req_ready_o = reset & ~w_force_upd & ~pred_flush_i;
  assign w_issue_pred = pred_req_valid_i & pred_req_ready_o;
  // A forced drain wins over fetch; otherwise updates fill cycles fetch leaves idle.
  assign w_issue_upd  = reset & ~w_empty & (w_force_upd | ~w_issue_pred);
  assign upd_ready_o  = reset & ~w_full;
  assign w_push       = upd_valid_i & upd_ready_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
    end
    if (w_issue_upd) begin
      rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
    end
    case ({w_push, w_issue_upd})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pend_d = w_issue_pred;
    tag_d  = w_issue_pred ? pred_req_tag_i : tag_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      tag_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      tag_q    <= tag_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_pc_q[wr_ptr_q] <= upd_pc_i;
      mem_tk_q[wr_ptr_q] <= upd_taken_i;
    end
  end

  assign bp_req_valid_o    = w_issue_pred;
  assign bp_req_pc_o       = reset ? pred_req_pc_i : 64'd0;
  assign bp_update_valid_o = w_issue_upd;
  assign bp_update_pc_o    = w_issue_upd ? mem_pc_q[rd_ptr_q] : 64'd0;
  assign bp_update_taken_o = w_issue_upd & mem_tk_q[rd_ptr_q];

  assign pred_resp_valid_o = reset & pend_q & ~pred_flush_i;
  assign pred_resp_tag_o   = reset ? tag_q : '0;
  assign pred_resp_taken_o = reset & bp_req_taken_i;
  assign upd_count_o       = reset ? count_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_bpd_harness_sequencer.sv
`default_nettype none
// ============================================================================
// tb_bpd_harness_sequencer: random stimulus, queue-based reference model and scoreboard monitor
// Revision: 1.0
// ============================================================================
module tb_bpd_harness_sequencer;

  localparam int UPD_DEPTH    = 8;
  localparam int TAG_W        = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(UPD_DEPTH) + 1;

  typedef struct {
    int               cyc;
    logic [63:0]      pc;
    logic             tk;
    logic [TAG_W-1:0] tag;
  } ev_t;

  typedef struct {
    int          cyc;
    logic        rst;
    logic        rdy;
    logic        urdy;
    logic [CW-1:0] cnt;
  } st_t;

  logic             clock;
  logic             reset;
  logic             pred_req_valid_i;
  logic             pred_req_ready_o;
  logic [63:0]      pred_req_pc_i;
  logic [TAG_W-1:0] pred_req_tag_i;
  logic             pred_flush_i;
  logic             pred_resp_valid_o;
  logic [TAG_W-1:0] pred_resp_tag_o;
  logic             pred_resp_taken_o;
  logic             upd_valid_i;
  logic             upd_ready_o;
  logic [63:0]      upd_pc_i;
  logic             upd_taken_i;
  logic [CW-1:0]    upd_count_o;
  logic             bp_req_valid_o;
  logic [63:0]      bp_req_pc_o;
  logic             bp_req_taken_i;
  logic             bp_update_valid_o;
  logic [63:0]      bp_update_pc_o;
  logic             bp_update_taken_o;

  bpd_harness_sequencer #(
    .UPD_DEPTH   (UPD_DEPTH),
    .TAG_W       (TAG_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .pred_req_valid_i (pred_req_valid_i),
    .pred_req_ready_o (pred_req_ready_o),
    .pred_req_pc_i    (pred_req_pc_i),
    .pred_req_tag_i   (pred_req_tag_i),
    .pred_flush_i     (pred_flush_i),
    .pred_resp_valid_o(pred_resp_valid_o),
    .pred_resp_tag_o  (pred_resp_tag_o),
    .pred_resp_taken_o(pred_resp_taken_o),
    .upd_valid_i      (upd_valid_i),
    .upd_ready_o      (upd_ready_o),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_count_o      (upd_count_o),
    .bp_req_valid_o   (bp_req_valid_o),
    .bp_req_pc_o      (bp_req_pc_o),
    .bp_req_taken_i   (bp_req_taken_i),
    .bp_update_valid_o(bp_update_valid_o),
    .bp_update_pc_o   (bp_update_pc_o),
    .bp_update_taken_o(bp_update_taken_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Expected-event scoreboards, each entry stamped with the cycle it must appear in.
  st_t stq[$];
  ev_t rq[$];
  ev_t uq[$];
  ev_t pq[$];

  // Reference state: buffered updates in order, plus the one outstanding prediction.
  ev_t              mq[$];
  bit               pend;
  logic [TAG_W-1:0] pend_tag;
`ifdef BPD_SEQ_STARVE_GUARD_EN
  int               deferred;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_cycle(input int p_rst, input int p_pred, input int p_flush, input int p_upd);
    bit  in_rst;
    int  sz;
    bit  frc;
    bit  rdy;
    bit  issp;
    bit  issu;
    st_t st;
    ev_t e;
    @(posedge clock);
    #1;
    cyc++;
    in_rst           = ($urandom_range(99) < p_rst);
    reset            = ~in_rst;
    pred_req_valid_i = ($urandom_range(99) < p_pred);
    pred_req_pc_i    = {$urandom, $urandom};
    pred_req_tag_i   = TAG_W'($urandom);
    pred_flush_i     = ($urandom_range(99) < p_flush);
    upd_valid_i      = ($urandom_range(99) < p_upd);
    upd_pc_i         = {$urandom, $urandom};
    upd_taken_i      = 1'($urandom_range(1));
    bp_req_taken_i   = 1'($urandom_range(1));
    st.cyc = cyc;
    st.rst = in_rst;
    if (in_rst) begin
      st.rdy  = 1'b0;
      st.urdy = 1'b0;
      st.cnt  = '0;
      stq.push_back(st);
      mq.delete();
      pend = 1'b0;
`ifdef BPD_SEQ_STARVE_GUARD_EN
      deferred = 0;
`endif
      return;
    end
    sz  = mq.size();
    frc = (sz == UPD_DEPTH);
`ifdef BPD_SEQ_STARVE_GUARD_EN
    if (deferred == STARVE_LIMIT) frc = 1'b1;
`endif
    rdy  = !frc && !pred_flush_i;
    issp = pred_req_valid_i && rdy;
    issu = (sz > 0) && (frc || !issp);
    st.rdy  = rdy;
    st.urdy = (sz < UPD_DEPTH);
    st.cnt  = CW'(sz);
    stq.push_back(st);
    if (issp) begin
      e.cyc = cyc; e.pc = pred_req_pc_i; e.tk = 1'b0; e.tag = '0;
      rq.push_back(e);
    end
    if (pend && !pred_flush_i) begin
      e.cyc = cyc; e.pc = 64'd0; e.tk = bp_req_taken_i; e.tag = pend_tag;
      pq.push_back(e);
    end
    if (issu) begin
      e = mq.pop_front();
      e.cyc = cyc;
      uq.push_back(e);
    end
`ifdef BPD_SEQ_STARVE_GUARD_EN
    if (sz == 0 || issu) deferred = 0;
    else if (deferred < STARVE_LIMIT) deferred++;
`endif
    if (upd_valid_i && sz < UPD_DEPTH) begin
      e.cyc = 0; e.pc = upd_pc_i; e.tk = upd_taken_i; e.tag = '0;
      mq.push_back(e);
    end
    pend     = issp;
    pend_tag = pred_req_tag_i;
  endtask

  always @(negedge clock) begin : monitor
    st_t s;
    ev_t e;
    if (cyc > 0) begin
      if (stq.size() == 0 || stq[0].cyc != cyc) begin
        chk("status_entry_present", 64'(stq.size()), 64'd1);
      end else begin
        s = stq.pop_front();
        chk("pred_req_ready", 64'(pred_req_ready_o), 64'(s.rdy));
        chk("upd_ready", 64'(upd_ready_o), 64'(s.urdy));
        chk("upd_count", 64'(upd_count_o), 64'(s.cnt));
        if (s.rst) begin
          chk("reset_ctrl_outputs",
              64'({pred_resp_valid_o, pred_resp_tag_o, pred_resp_taken_o,
                   bp_req_valid_o, bp_update_valid_o, bp_update_taken_o}), 64'd0);
          chk("reset_bp_req_pc", bp_req_pc_o, 64'd0);
          chk("reset_bp_update_pc", bp_update_pc_o, 64'd0);
        end
      end
      chk("bp_exclusive", 64'(bp_req_valid_o & bp_update_valid_o), 64'd0);

      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        e = rq.pop_front();
        chk("bp_req_valid", 64'(bp_req_valid_o), 64'd1);
        if (bp_req_valid_o === 1'b1) chk("bp_req_pc", bp_req_pc_o, e.pc);
      end else begin
        chk("bp_req_valid", 64'(bp_req_valid_o), 64'd0);
      end

      if (uq.size() > 0 && uq[0].cyc == cyc) begin
        e = uq.pop_front();
        chk("bp_update_valid", 64'(bp_update_valid_o), 64'd1);
        if (bp_update_valid_o === 1'b1) begin
          chk("bp_update_pc", bp_update_pc_o, e.pc);
          chk("bp_update_taken", 64'(bp_update_taken_o), 64'(e.tk));
        end
      end else begin
        chk("bp_update_valid", 64'(bp_update_valid_o), 64'd0);
      end

      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        e = pq.pop_front();
        chk("pred_resp_valid", 64'(pred_resp_valid_o), 64'd1);
        if (pred_resp_valid_o === 1'b1) begin
          chk("pred_resp_tag", 64'(pred_resp_tag_o), 64'(e.tag));
          chk("pred_resp_taken", 64'(pred_resp_taken_o), 64'(e.tk));
        end
      end else begin
        chk("pred_resp_valid", 64'(pred_resp_valid_o), 64'd0);
      end
    end
  end

  initial begin
    reset            = 1'b0;
    pred_req_valid_i = 1'b0;
    pred_req_pc_i    = '0;
    pred_req_tag_i   = '0;
    pred_flush_i     = 1'b0;
    upd_valid_i      = 1'b0;
    upd_pc_i         = '0;
    upd_taken_i      = 1'b0;
    bp_req_taken_i   = 1'b0;
    pend             = 1'b0;
    pend_tag         = '0;
`ifdef BPD_SEQ_STARVE_GUARD_EN
    deferred         = 0;
`endif
    repeat (2)  drive_cycle(100, 50, 20, 50);
    // Back-to-back predictions from an empty FIFO.
    repeat (20) drive_cycle(0, 100, 0, 0);
    // Update burst with fetch quiet, then drain.
    repeat (8)  drive_cycle(0, 0, 0, 100);
    repeat (12) drive_cycle(0, 0, 0, 0);
    // Fetch saturating while commit fills the FIFO: forced drains.
    repeat (30) drive_cycle(0, 100, 0, 100);
    repeat (12) drive_cycle(0, 0, 0, 0);
    // Single queued update starved by continuous fetch.
    drive_cycle(0, 100, 0, 100);
    repeat (12) drive_cycle(0, 100, 0, 0);
    repeat (4)  drive_cycle(0, 0, 0, 0);
    // Reset with updates buffered and a response outstanding.
    repeat (3)  drive_cycle(0, 100, 0, 100);
    drive_cycle(100, 100, 0, 0);
    repeat (6)  drive_cycle(0, 0, 0, 0);
    // Mixed traffic with flushes, then with sporadic resets.
    repeat (400) drive_cycle(0, 70, 15, 50);
    repeat (300) drive_cycle(2, 60, 20, 60);
    repeat (16) drive_cycle(0, 0, 0, 0);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", 64'(stq.size() + rq.size() + uq.size() + pq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
